// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback block.
//   DATA_WIDTH / ADDR_WIDTH / NUM_REGS : default geometry (32 x 32-bit)
//   ZERO_REG                           : hardwired-zero register index
//   regfile_state_t                    : clear sequencer states
package regfile_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 0;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } regfile_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer for the register file. After reset it walks every
// register index once, requesting a zero write each cycle, then parks
// in READY until the next reset.
//   clk         : clock
//   reset_input : synchronous active-high reset, restarts the sweep at 0
//   o_busy      : high while the sweep is running
//   o_clr_we    : zero-write request into the storage write mux
//   o_clr_addr  : register index being cleared
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
   input  logic                  clk,
   input  logic                  reset_input,
   output logic                  o_busy,
   output logic                  o_clr_we,
   output logic [ADDR_WIDTH-1:0] o_clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   regfile_state_t        r_state;
   regfile_state_t        w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset_input) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_clr_we    = 1'b0;
      case (r_state)
         CLEAR: begin
            o_clr_we  = 1'b1;
            w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
            // Last index is written this cycle; busy drops on this edge.
            if (r_cnt == LAST_IDX) begin
               w_state_nxt = READY;
               w_cnt_nxt   = '0;
            end
         end
         default: ;
      endcase
   end

   assign o_busy     = (r_state == CLEAR);
   assign o_clr_addr = r_cnt;

endmodule

// File: rtl/register_file_writeback.sv
// Register file at the writeback end of the R-format execute datapath.
// Stores ALU results into a NUM_REGS x DATA_WIDTH array and returns two
// source operands through a registered, 1-cycle-latency read port.
// Register 0 always reads as zero and ignores writes. After reset a clear
// sweep zeroes the array; requests are ignored while busy is high.
//   clk, reset_input                 : clock, synchronous active-high reset
//   wr_en, wr_address, wr_data       : ALU result write
//   rd_req, rs_address, rt_address   : operand read request
//   rs_data, rt_data, rd_valid       : registered operands, valid pulse
//   busy                             : clear sweep in progress
// Optional build macro REGFILE_BYPASS_EN: forwards a same-cycle write to
// a matching read address instead of returning the pre-write contents.
module register_file_writeback
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
   input  logic                  clk,
   input  logic                  reset_input,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_address,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rs_address,
   input  logic [ADDR_WIDTH-1:0] rt_address,
   output logic [DATA_WIDTH-1:0] rs_data,
   output logic [DATA_WIDTH-1:0] rt_data,
   output logic                  rd_valid,
   output logic                  busy
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

   logic                  w_busy;
   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_addr;
   logic                  w_user_we;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_rs_val;
   logic [DATA_WIDTH-1:0] w_rt_val;

   regfile_clear_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_clear_fsm (
      .clk         (clk),
      .reset_input (reset_input),
      .o_busy      (w_busy),
      .o_clr_we    (w_clr_we),
      .o_clr_addr  (w_clr_addr)
   );

   // Clear sweep owns the write port while busy; user writes are dropped.
   assign w_user_we = !w_busy && wr_en && (wr_address != ZERO_ADDR);
   assign w_we      = w_clr_we || w_user_we;
   assign w_waddr   = w_clr_we ? w_clr_addr : wr_address;
   assign w_wdata   = w_clr_we ? '0 : wr_data;

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      w_rs_val = r_mem[rs_address];
      w_rt_val = r_mem[rt_address];
      if (w_user_we && (wr_address == rs_address)) w_rs_val = wr_data;
      if (w_user_we && (wr_address == rt_address)) w_rt_val = wr_data;
      if (rs_address == ZERO_ADDR) w_rs_val = '0;
      if (rt_address == ZERO_ADDR) w_rt_val = '0;
   end
`else
   always_comb begin
      w_rs_val = (rs_address == ZERO_ADDR) ? '0 : r_mem[rs_address];
      w_rt_val = (rt_address == ZERO_ADDR) ? '0 : r_mem[rt_address];
   end
`endif

   // Operands hold their last value between requests.
   always_ff @(posedge clk) begin
      if (reset_input) begin
         rd_valid <= 1'b0;
         rs_data  <= '0;
         rt_data  <= '0;
      end else if (!w_busy && rd_req) begin
         rd_valid <= 1'b1;
         rs_data  <= w_rs_val;
         rt_data  <= w_rt_val;
      end else begin
         rd_valid <= 1'b0;
      end
   end

   assign busy = w_busy;

endmodule

// File: tb/tb_register_file_writeback.sv
module tb_register_file_writeback;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_input = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_address = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rs_address = '0;
   logic [AW-1:0] rt_address = '0;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;
   logic          rd_valid;
   logic          busy;

   int checks = 0;
   int errors = 0;

   register_file_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .clk         (clk),
      .reset_input (reset_input),
      .wr_en       (wr_en),
      .wr_address  (wr_address),
      .wr_data     (wr_data),
      .rd_req      (rd_req),
      .rs_address  (rs_address),
      .rt_address  (rt_address),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .rd_valid    (rd_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a clear countdown, an array of register values,
   // and the operand pair that the last accepted request should produce.
   int          m_clear_left = 0;
   bit          m_seen = 1'b0;
   bit          m_valid = 1'b0;
   logic [DW-1:0] m_rs = '0, m_rt = '0;
   logic [DW-1:0] m_mem [NR];

   function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (BYPASS && wr_en && wr_address != 0 && wr_address == a) return wr_data;
      return m_mem[a];
   endfunction

   always @(posedge clk) begin
      if (reset_input) begin
         m_seen       = 1'b1;
         m_clear_left = NR;
         m_valid      = 1'b0;
         m_rs         = '0;
         m_rt         = '0;
         for (int i = 0; i < NR; i++) m_mem[i] = '0;
      end else if (m_clear_left > 0) begin
         m_clear_left = m_clear_left - 1;
         m_valid      = 1'b0;
      end else begin
         m_valid = rd_req;
         if (rd_req) begin
            m_rs = m_read(rs_address);
            m_rt = m_read(rt_address);
         end
         if (wr_en && wr_address != 0) m_mem[wr_address] = wr_data;
      end
   end

   always @(negedge clk) begin
      if (m_seen) begin
         chk("busy", {31'd0, busy}, {31'd0, (m_clear_left > 0)});
         chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
         chk("rs_data", rs_data, m_rs);
         chk("rt_data", rt_data, m_rt);
      end
   end

   // Inputs change 1 time unit after a rising edge; outputs are then settled.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en = 1'b1; wr_address = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] s, input logic [AW-1:0] t);
      rd_req = 1'b1; rs_address = s; rt_address = t;
      step();
      rd_req = 1'b0;
   endtask

   task automatic wait_clear();
      int n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      chk("clear_len", DW'(n), DW'(32));
   endtask

   initial begin
      // 1: reset for 3 cycles, clear length, everything reads zero
      reset_input = 1'b1;
      repeat (3) step();
      chk("reset_busy", {31'd0, busy}, 32'd1);
      chk("reset_valid", {31'd0, rd_valid}, 32'd0);
      reset_input = 1'b0;
      wait_clear();
      for (int i = 0; i < NR; i++) rd(AW'(i), AW'(NR - 1 - i));
      chk("post_clear_rs", rs_data, 32'h0);
      chk("post_clear_valid", {31'd0, rd_valid}, 32'd1);
      step();

      // 2: basic write / read and output hold
      wr(5'd9, 32'h0000000A);
      wr(5'd10, 32'h00000014);
      rd(5'd9, 5'd10);
      chk("rd9", rs_data, 32'h0000000A);
      chk("rd10", rt_data, 32'h00000014);
      chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd1);
      step();
      chk("valid_drop", {31'd0, rd_valid}, 32'd0);
      chk("hold_rs", rs_data, 32'h0000000A);

      // back-to-back reads, same address on both ports
      rd_req = 1'b1; rs_address = 5'd10; rt_address = 5'd10;
      step();
      rs_address = 5'd9; rt_address = 5'd9;
      step();
      rd_req = 1'b0;
      chk("b2b_rs", rs_data, 32'h0000000A);
      chk("b2b_valid", {31'd0, rd_valid}, 32'd1);

      // 3: writes to register 0 are discarded
      wr(5'd0, 32'hDEADBEEF);
      rd(5'd0, 5'd0);
      chk("zero_rs", rs_data, 32'h0);
      chk("zero_rt", rt_data, 32'h0);

      // 4: simultaneous write and read of the same register
      wr(5'd13, 32'h00000005);
      wr_en = 1'b1; wr_address = 5'd13; wr_data = 32'h0000001E;
      rd_req = 1'b1; rs_address = 5'd13; rt_address = 5'd9;
      step();
      wr_en = 1'b0; rd_req = 1'b0;
      chk("same_cycle_rs", rs_data, BYPASS ? 32'h0000001E : 32'h00000005);
      chk("same_cycle_rt", rt_data, 32'h0000000A);
      rd(5'd13, 5'd13);
      chk("after_write_rs", rs_data, 32'h0000001E);

      // 5: requests during CLEAR are ignored
      wr(5'd5, 32'h00000055);
      reset_input = 1'b1;
      step();
      reset_input = 1'b0;
      repeat (10) step();
      wr_en = 1'b1; wr_address = 5'd5; wr_data = 32'h00000077;
      rd_req = 1'b1; rs_address = 5'd5; rt_address = 5'd5;
      step();
      wr_en = 1'b0; rd_req = 1'b0;
      chk("clear_no_valid", {31'd0, rd_valid}, 32'd0);
      chk("clear_busy", {31'd0, busy}, 32'd1);
      begin
         int n = 11;
         while (busy && n < 40) begin
            step();
            n++;
         end
         chk("clear_len_mid", DW'(n), DW'(32));
      end
      rd(5'd5, 5'd0);
      chk("reg5_cleared", rs_data, 32'h0);

      // 6: reset in the middle of a read stream
      wr(5'd7, 32'h00000099);
      rd_req = 1'b1; rs_address = 5'd7; rt_address = 5'd7;
      step();
      chk("stream_rs", rs_data, 32'h00000099);
      reset_input = 1'b1;
      step();
      chk("rst_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_rs", rs_data, 32'h0);
      reset_input = 1'b0;
      wait_clear();
      rd_req = 1'b0;
      rd(5'd7, 5'd7);
      chk("reg7_cleared", rs_data, 32'h0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
